// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   PC_W / INSTR_W : fetch address and instruction widths
//   DEPTH          : instruction queue entries; also the total request credit
//   RESET_PC       : fetch address after reset
package fetch_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 2;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   typedef logic [PC_W-1:0]    pc_t;
   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   localparam pc_t RESET_PC = '0;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      pc_t    pc;
      instr_t instr;
   } fetch_entry_t;

   // Word-addressed increment; wraps naturally at 2^PC_W.
   function automatic pc_t pc_inc(input pc_t pc);
      return pc + pc_t'(1);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO used for both the instruction queue and the
// request tag FIFO.
//   clk, rst_n : clock, async active-low reset (clears contents too)
//   push_i     : write wdata_i at tail (ignored when full without a pop)
//   pop_i      : drop head (ignored when empty)
//   flush_i    : empty the FIFO; wins over push/pop
//   rdata_o    : head entry
//   count_o    : number of valid entries
module fetch_queue #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A push into a full queue is only honoured when the head leaves in the same cycle.
   assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | pop_i);
   assign do_pop  = pop_i & (count_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues req/gnt/rvalid reads to
// instruction memory under a credit limit, and queues returned instructions
// for decode behind a valid/ready handshake. Redirects retarget the PC and
// squash buffered and in-flight instructions.
//   clk, rst_n                  : clock, async active-low reset
//   redirect_valid, redirect_pc : retarget fetch stream
//   imem_req/addr/gnt           : request channel
//   imem_rvalid/rdata           : in-order response channel
//   if_valid/instr/pc, id_ready : decode handshake
//
// state | meaning
// RUN   | normal fetch, every response is kept
// DRAIN | responses to pre-redirect requests still due; they are discarded
module instr_fetch_unit
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   input  logic               id_ready
);

   fetch_state_e state_q, state_d;
   pc_t          fetch_pc_q, fetch_pc_d;
   cnt_t         out_q, out_d;
   cnt_t         drop_q, drop_d;
   cnt_t         q_count, tag_count;
   pc_t          tag_head;
   fetch_entry_t head, wentry;
   logic [CNT_W:0] credit_used;
   logic         grant, rsp, rsp_keep, deq;

   assign credit_used = {1'b0, out_q} + {1'b0, q_count};

   // Gated by rst_n so the request line is low while reset is held.
   assign imem_req  = rst_n & ~redirect_valid & (credit_used < (CNT_W+1)'(DEPTH));
   assign imem_addr = fetch_pc_q;
   assign grant     = imem_req & imem_gnt;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp      = imem_rvalid & (out_q != '0);
   assign rsp_keep = rsp & ~redirect_valid & (drop_q == '0) & (tag_count != '0);

   assign if_valid = (q_count != '0) & ~redirect_valid;
   assign deq      = if_valid & id_ready;
   assign if_instr = head.instr;
   assign if_pc    = head.pc;

   assign wentry.pc    = tag_head;
   assign wentry.instr = imem_rdata;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      out_d      = out_q + cnt_t'(grant) - cnt_t'(rsp);
      drop_d     = drop_q;
      state_d    = state_q;
      if (grant) fetch_pc_d = pc_inc(fetch_pc_q);
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old stream.
         fetch_pc_d = redirect_pc;
         drop_d     = out_d;
         state_d    = (out_d != '0) ? DRAIN : RUN;
      end else begin
         if (rsp && drop_q != '0) drop_d = drop_q - cnt_t'(1);
         case (state_q)
            RUN:     state_d = RUN;
            DRAIN:   if (drop_d == '0) state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   // Tags of squashed requests are flushed; dropped responses never pop a tag.
   fetch_queue #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (grant),
      .pop_i   (rsp_keep),
      .flush_i (redirect_valid),
      .wdata_i (imem_addr),
      .rdata_o (tag_head),
      .count_o (tag_count)
   );

   fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rsp_keep),
      .pop_i   (deq),
      .flush_i (redirect_valid),
      .wdata_i (wentry),
      .rdata_o (head),
      .count_o (q_count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         redirect_valid;
   logic [7:0]   redirect_pc;
   logic         imem_req;
   logic [7:0]   imem_addr;
   logic         imem_gnt;
   logic         imem_rvalid;
   logic [31:0]  imem_rdata;
   logic         if_valid;
   logic [31:0]  if_instr;
   logic [7:0]   if_pc;
   logic         id_ready;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [7:0]   exp_pc, exp_addr;
   int           hs_n;
   logic         mem_hold;
   logic         found;

   logic [7:0]   pend [8];
   logic [2:0]   pwr, prd;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready)
   );

   function automatic logic [31:0] img(input logic [7:0] a);
      return {a, 8'h5A, ~a, 8'hA5};
   endfunction

   // Memory model: always grants, answers in order one cycle or more later.
   assign imem_gnt    = imem_req;
   assign imem_rvalid = !mem_hold && (pwr != prd);
   assign imem_rdata  = img(pend[prd]);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwr <= '0;
         prd <= '0;
      end else begin
         if (imem_rvalid) prd <= prd + 3'd1;
         if (imem_req && imem_gnt) begin
            pend[pwr] <= imem_addr;
            pwr       <= pwr + 3'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mon();
      if (if_valid && id_ready) begin
         chk("hs_pc", {24'h0, if_pc}, {24'h0, exp_pc});
         chk("hs_instr", if_instr, img(exp_pc));
         exp_pc = exp_pc + 8'd1;
         hs_n++;
      end
      if (imem_req && imem_gnt) begin
         chk("gnt_addr", {24'h0, imem_addr}, {24'h0, exp_addr});
         exp_addr = exp_addr + 8'd1;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         mon();
         adv();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      adv();
      rst_n    = 1'b1;
      exp_pc   = 8'h00;
      exp_addr = 8'h00;
      hs_n     = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic t1_v [7];
      logic t1_r [7];
      logic t2_v [5];
      logic t2_r [5];
      t1_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      t1_r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      t2_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      t2_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      id_ready       = 1'b1;
      mem_hold       = 1'b0;
      exp_pc         = 8'h00;
      exp_addr       = 8'h00;
      hs_n           = 0;
      adv();
      adv();
      chk("rst_req",   {31'h0, imem_req}, 32'h0);
      chk("rst_ifv",   {31'h0, if_valid}, 32'h0);
      chk("rst_addr",  {24'h0, imem_addr}, 32'h0);
      chk("rst_ifpc",  {24'h0, if_pc}, 32'h0);
      chk("rst_instr", if_instr, 32'h0);

      // Free-running fetch from reset, decode always ready.
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("t1_req", {31'h0, imem_req}, {31'h0, t1_r[i]});
         chk("t1_ifv", {31'h0, if_valid}, {31'h0, t1_v[i]});
         mon();
         adv();
      end
      chk("t1_hs", hs_n, 4);

      // Decode stalls: credits run out after two grants, head holds at pc 0.
      do_reset();
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_req", {31'h0, imem_req}, {31'h0, t2_r[i]});
         chk("t2_ifv", {31'h0, if_valid}, {31'h0, t2_v[i]});
         if (t2_v[i]) chk("t2_ifpc", {24'h0, if_pc}, 32'h0);
         mon();
         adv();
      end
      id_ready = 1'b1;
      run(8);
      chk("t2_hs", hs_n, 6);

      // Redirect with two responses outstanding.
      do_reset();
      mem_hold = 1'b1;
      run(3);
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      exp_pc         = 8'h40;
      exp_addr       = 8'h40;
      hs_n           = 0;
      @(negedge clk);
      chk("t3_rd_req", {31'h0, imem_req}, 32'h0);
      chk("t3_rd_ifv", {31'h0, if_valid}, 32'h0);
      mon();
      adv();
      redirect_valid = 1'b0;
      mem_hold       = 1'b0;
      @(negedge clk);
      chk("t3_flush_ifv", {31'h0, if_valid}, 32'h0);
      chk("t3_addr", {24'h0, imem_addr}, 32'h40);
      chk("t3_req_full", {31'h0, imem_req}, 32'h0);
      mon();
      adv();
      run(8);
      chk("t3_hs", hs_n, 4);

      // PC wrap across 0xFF.
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFE;
      exp_pc         = 8'hFE;
      exp_addr       = 8'hFE;
      hs_n           = 0;
      run(1);
      redirect_valid = 1'b0;
      run(12);
      chk("t4_hs_min", {31'h0, hs_n >= 4}, 32'h1);

      // Redirect in a cycle carrying both a response and a handshake.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (if_valid && imem_rvalid && id_ready) begin
            found          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = 8'h80;
            #1;
            chk("t5_rd_ifv", {31'h0, if_valid}, 32'h0);
            chk("t5_rd_req", {31'h0, imem_req}, 32'h0);
            exp_pc   = 8'h80;
            exp_addr = 8'h80;
            hs_n     = 0;
         end
         mon();
         adv();
      end
      if (!found) chk("t5_found", 32'h0, 32'h1);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t5_ifv", {31'h0, if_valid}, 32'h0);
      chk("t5_req", {31'h0, imem_req}, 32'h1);
      chk("t5_addr", {24'h0, imem_addr}, 32'h80);
      mon();
      adv();
      run(6);
      chk("t5_hs_min", {31'h0, hs_n >= 2}, 32'h1);

      // Asynchronous reset with the queue full.
      id_ready = 1'b0;
      run(5);
      @(negedge clk);
      chk("t6_full_ifv", {31'h0, if_valid}, 32'h1);
      chk("t6_full_req", {31'h0, imem_req}, 32'h0);
      adv();
      rst_n = 1'b0;
      #1;
      chk("t6_ifv", {31'h0, if_valid}, 32'h0);
      chk("t6_req", {31'h0, imem_req}, 32'h0);
      chk("t6_ifpc", {24'h0, if_pc}, 32'h0);
      chk("t6_instr", if_instr, 32'h0);
      chk("t6_addr", {24'h0, imem_addr}, 32'h0);
      adv();
      rst_n    = 1'b1;
      id_ready = 1'b1;
      exp_pc   = 8'h00;
      exp_addr = 8'h00;
      hs_n     = 0;
      @(negedge clk);
      chk("t6_restart_req", {31'h0, imem_req}, 32'h1);
      chk("t6_restart_addr", {24'h0, imem_addr}, 32'h0);
      mon();
      adv();
      run(6);
      chk("t6_hs_min", {31'h0, hs_n >= 2}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
